rsa_engine_arbiter: RTL and testbench

RSA_ENGINE_ARBITER -- requirements
Module: rsa_engine_arbiter

---
 rtl/rsa_engine_arbiter.sv | 136 +++++++++++++
 tb/tb_rsa_engine_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_engine_arbiter.sv
// Round-robin arbiter sharing one modular-exponentiation engine among N_REQ requesters.
// One job at a time: grant, start the engine, wait for done or timeout, return the result.
module rsa_engine_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [RES_W-1:0]          rsp_data,
    output logic                      rsp_timeout,
    output logic [DATA_W-1:0]         eng_data,
    output logic                      eng_start,
    input  logic                      eng_done,
    input  logic [RES_W-1:0]          eng_result,
    output logic                      busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] eng_data_q, eng_data_d;
    logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic [DATA_W-1:0] req_data_arr [N_REQ];
    logic              arb_found;
    logic [IDX_W-1:0]  arb_idx;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        assign req_ready[gi]    = (state_q == ST_ISSUE) && (grant_q == IDX_W'(gi));
        assign rsp_valid[gi]    = (state_q == ST_RESP)  && (grant_q == IDX_W'(gi));
    end

    // Search upward from the requester after the last one served, wrapping at N_REQ.
    always_comb begin
        int cand;
        cand      = 0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(last_grant_q) + 1 + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!arb_found && req_valid[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        eng_data_d    = eng_data_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d    = arb_idx;
                    eng_data_d = req_data_arr[arb_idx];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last allowed cycle still beats the timeout.
                if (eng_done) begin
                    rsp_data_d    = eng_result;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_grant_q  <= IDX_W'(N_REQ - 1);
            cnt_q         <= '0;
            eng_data_q    <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            eng_data_q    <= eng_data_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign eng_start   = (state_q == ST_ISSUE);
    assign eng_data    = eng_data_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// Scoreboard bench for rsa_engine_arbiter: a short-timeout instance for random and
// boundary traffic, plus a default-timeout instance for the long-latency single job.
module tb_rsa_engine_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int RW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [N-1:0]  req_valid, req_ready, rsp_valid;
    logic [N*DW-1:0] req_data;
    logic [RW-1:0] rsp_data, eng_result;
    logic          rsp_timeout, eng_start, eng_done, busy;
    logic [DW-1:0] eng_data;

    logic [N-1:0]  l_req_valid, l_req_ready, l_rsp_valid;
    logic [N*DW-1:0] l_req_data;
    logic [RW-1:0] l_rsp_data, l_eng_result;
    logic          l_rsp_timeout, l_eng_start, l_eng_done, l_busy;
    logic [DW-1:0] l_eng_data;

    rsa_engine_arbiter #(.N_REQ(N), .DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .eng_data(eng_data), .eng_start(eng_start),
        .eng_done(eng_done), .eng_result(eng_result), .busy(busy)
    );

    rsa_engine_arbiter #(.N_REQ(N), .DATA_W(DW), .RES_W(RW)) dut_long (
        .clk(clk), .rst_n(rst_n), .req_valid(l_req_valid), .req_data(l_req_data),
        .req_ready(l_req_ready), .rsp_valid(l_rsp_valid), .rsp_data(l_rsp_data),
        .rsp_timeout(l_rsp_timeout), .eng_data(l_eng_data), .eng_start(l_eng_start),
        .eng_done(l_eng_done), .eng_result(l_eng_result), .busy(l_busy)
    );

    typedef struct { int g; logic [DW-1:0] d; } iss_t;
    typedef struct { int g; logic [RW-1:0] r; logic tmo; } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    rsp_t lrsp_q[$];

    int n_pass = 0;
    int n_total = 0;
    int exp_phase = 0;     // 0 idle, 1 issue, 2 wait, 3 resp
    bit mon_en = 1'b0;

    logic [N-1:0]  pending;
    logic [DW-1:0] pdata [N];
    int last_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int rr_next(input int last, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_req();
        req_valid = pending;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pdata[i];
    endtask

    // One job, entered in an IDLE cycle; lat = WAIT cycle carrying eng_done (0 = never).
    task automatic run_job(input logic [N-1:0] add, input int lat, input bit keep,
                           input bit rst_mid, input bit spur);
        int g, w, b;
        bit timed;
        logic [RW-1:0] res, er;
        logic [N-1:0] newbits;
        newbits = add & ~pending;
        for (int i = 0; i < N; i++) if (newbits[i]) pdata[i] = DW'($urandom);
        pending = pending | add;
        if (pending == '0) begin
            b = $urandom_range(0, N-1);
            pending[b] = 1'b1;
            pdata[b] = DW'($urandom);
        end
        drive_req();
        g = rr_next(last_m, pending);
        iss_q.push_back('{g, pdata[g]});
        timed = !(lat >= 1 && lat <= TO);
        w = timed ? TO : lat;
        res = RW'($urandom);
        er = timed ? '0 : res;
        if (!rst_mid) rsp_q.push_back('{g, er, timed});
        @(posedge clk); #1;
        exp_phase = 1;
        if (!keep) pending[g] = 1'b0;
        drive_req();
        eng_done = spur;
        eng_result = RW'($urandom);
        @(posedge clk); #1;
        exp_phase = 2;
        for (int k = 1; k <= w; k++) begin
            if (rst_mid && k == 2) begin
                eng_done = 1'b0;
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                exp_phase = 0;
                last_m = N - 1;
                pending = '0;
                drive_req();
                check("rst_eng_data", 32'(eng_data), 32'd0);
                check("rst_rsp_data", 32'(rsp_data), 32'd0);
                check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
                eng_done = 1'b1;
                eng_result = RW'($urandom);
                @(posedge clk); #1;
                eng_done = 1'b0;
                return;
            end
            eng_done = (k == lat);
            eng_result = (k == lat) ? res : RW'($urandom);
            @(posedge clk); #1;
        end
        exp_phase = 3;
        eng_done = spur;
        eng_result = RW'($urandom);
        last_m = g;
        @(posedge clk); #1;
        exp_phase = 0;
        eng_done = spur;
    endtask

    task automatic idle_cycles(input int n, input bit spur);
        for (int i = 0; i < n; i++) begin
            eng_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            eng_result = RW'($urandom);
            @(posedge clk); #1;
        end
        eng_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [3:0] pa, pe;
            logic [N-1:0] oh;
            iss_t ie;
            rsp_t re;
            pa = {busy, eng_start, |req_ready, |rsp_valid};
            pe = {exp_phase != 0, exp_phase == 1, exp_phase == 1, exp_phase == 3};
            check("phase", 32'(pa), 32'(pe));
            if (req_ready != '0 || eng_start) begin
                if (iss_q.size() == 0) check("issue_expected", 32'd0, 32'd1);
                else begin
                    ie = iss_q.pop_front();
                    oh = N'(1) << ie.g;
                    check("req_ready", 32'(req_ready), 32'(oh));
                    check("eng_data", 32'(eng_data), 32'(ie.d));
                end
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) check("rsp_expected", 32'd0, 32'd1);
                else begin
                    re = rsp_q.pop_front();
                    oh = N'(1) << re.g;
                    $display("rsp: requester %0d data 0x%0h timeout %0b", re.g, rsp_data, rsp_timeout);
                    check("rsp_valid", 32'(rsp_valid), 32'(oh));
                    check("rsp_data", 32'(rsp_data), 32'(re.r));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(re.tmo));
                end
            end
            if (l_rsp_valid != '0) begin
                if (lrsp_q.size() == 0) check("long_rsp_expected", 32'd0, 32'd1);
                else begin
                    re = lrsp_q.pop_front();
                    oh = N'(1) << re.g;
                    $display("long rsp: requester %0d data %0d timeout %0b", re.g, l_rsp_data, l_rsp_timeout);
                    check("long_rsp_valid", 32'(l_rsp_valid), 32'(oh));
                    check("long_rsp_data", 32'(l_rsp_data), 32'(re.r));
                    check("long_rsp_timeout", 32'(l_rsp_timeout), 32'(re.tmo));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_data = '0; eng_done = 1'b0; eng_result = '0;
        l_req_valid = '0; l_req_data = '0; l_eng_done = 1'b0; l_eng_result = '0;
        pending = '0;
        for (int i = 0; i < N; i++) pdata[i] = '0;
        last_m = N - 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_eng_start", 32'(eng_start), 32'd0);
        check("reset_eng_data", 32'(eng_data), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("reset_long_busy", 32'(l_busy), 32'd0);

        // Single long-latency job on the default-timeout instance.
        l_req_valid = 4'b0001;
        l_req_data[0 +: DW] = 8'd2;
        lrsp_q.push_back('{0, 16'd1752, 1'b0});
        check("long_start_before_grant", 32'(l_eng_start), 32'd0);
        @(posedge clk); #1;
        check("long_eng_start", 32'(l_eng_start), 32'd1);
        check("long_req_ready", 32'(l_req_ready), 32'b0001);
        check("long_eng_data", 32'(l_eng_data), 32'd2);
        l_req_valid = '0;
        repeat (10) @(posedge clk);
        #1;
        l_eng_done = 1'b1;
        l_eng_result = 16'd1752;
        @(posedge clk); #1;
        l_eng_done = 1'b0;
        @(posedge clk); #1;
        check("long_busy_after", 32'(l_busy), 32'd0);

        // All four requesting continuously: expect grants 0,1,2,3,0.
        for (int j = 0; j < 5; j++) run_job(4'b1111, 3, 1'b1, 1'b0, 1'b0);
        while (pending != '0) run_job('0, 2, 1'b0, 1'b0, 1'b0);

        // Timeout, then normal service, then done exactly at the timeout boundary.
        run_job(4'b0001, 0, 1'b0, 1'b0, 1'b0);
        run_job(4'b0010, 4, 1'b0, 1'b0, 1'b0);
        run_job(4'b0100, TO, 1'b0, 1'b0, 1'b1);
        run_job(4'b0100, TO + 1, 1'b0, 1'b0, 1'b1);

        // Reset during WAIT, then the next job must go to requester 0.
        run_job(4'b1000, 0, 1'b0, 1'b1, 1'b0);
        run_job(4'b1111, 1, 1'b0, 1'b0, 1'b0);
        while (pending != '0) run_job('0, 2, 1'b0, 1'b0, 1'b0);

        // Grant to 1, spurious done while idle, then 1010 must go to 3.
        run_job(4'b0010, 2, 1'b0, 1'b0, 1'b0);
        idle_cycles(3, 1'b1);
        run_job(4'b1010, 5, 1'b0, 1'b0, 1'b0);
        while (pending != '0) run_job('0, 2, 1'b0, 1'b0, 1'b0);

        for (int j = 0; j < 60; j++) begin
            int r;
            int lat;
            bit rm;
            r = $urandom_range(0, 9);
            if (r < 6) lat = $urandom_range(1, TO - 1);
            else if (r == 6) lat = TO;
            else if (r == 7) lat = TO + 1;
            else if (r == 8) lat = 0;
            else lat = $urandom_range(1, 3);
            rm = ($urandom_range(0, 14) == 0);
            if (rm) lat = 0;
            run_job(N'($urandom_range(0, 15)), lat, 1'($urandom_range(0, 1)), rm,
                    1'($urandom_range(0, 1)));
            if (pending == '0 && $urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3), 1'b1);
        end
        while (pending != '0) run_job('0, 2, 1'b0, 1'b0, 1'b0);
        idle_cycles(3, 1'b0);

        check("issue_queue_drained", 32'(iss_q.size()), 32'd0);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        check("long_queue_drained", 32'(lrsp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
